reg_writeback_buffer: RTL and testbench

//  Write-side initiator for the 8x16 register file: collects results from the ALU and load paths.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wb_fifo.sv | 98 +++++++++
 rtl/reg_writeback_buffer.sv | 126 ++++++++++++
 tb/tb_reg_writeback_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and widths for the 8x16 register file write path.
package regfile_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned NUM_REGS = 1 << ADDR_W;
   localparam int unsigned WB_DEPTH = 4;

   // One queued register write.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         enqueue request (ignored while full)
//   push_entry   entry to enqueue
//   pop          dequeue request (ignored while empty)
//   head         oldest entry (stale when empty; caller gates with empty)
//   entries      raw storage, indexed by slot
//   valid        per-slot occupancy
//   rd_ptr       slot index of the head entry
//   full, empty  registered queue status
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  wb_entry_t                    push_entry,
   input  logic                         pop,
   output wb_entry_t                    head,
   output wb_entry_t [DEPTH-1:0]        entries,
   output logic      [DEPTH-1:0]        valid,
   output logic      [$clog2(DEPTH)-1:0] rd_ptr,
   output logic                         full,
   output logic                         empty
);

   // DEPTH must be a power of two so the pointers wrap on their own width.
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t [DEPTH-1:0] mem_q;
   logic      [DEPTH-1:0] vld_q;
   logic      [PTR_W-1:0] wr_ptr_q;
   logic      [PTR_W-1:0] rd_ptr_q;
   logic      [CNT_W-1:0] count_q;
   logic      [CNT_W-1:0] count_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  push_ok;
   logic                  pop_ok;

   assign push_ok = push && !full_q;
   assign pop_ok  = pop && !empty_q;

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count_q + CNT_W'(1);
         2'b01:   count_nxt = count_q - CNT_W'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Storage, pointers and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         // Push and pop never share a slot: that needs empty or full, each blocking one side.
         if (pop_ok) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_nxt;
         full_q  <= (count_nxt == CNT_W'(DEPTH));
         empty_q <= (count_nxt == '0);
      end
   end

   assign head    = mem_q[rd_ptr_q];
   assign entries = mem_q;
   assign valid   = vld_q;
   assign rd_ptr  = rd_ptr_q;
   assign full    = full_q;
   assign empty   = empty_q;

   // Occupancy stays within bounds and pop never runs on an empty queue.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(pop_ok && (count_q == '0)));

endmodule : wb_fifo

// File: rtl/reg_writeback_buffer.sv
// Write-side initiator for the 8x16 register file: queues ALU and load
// results in order and retires one write per cycle, with bypass lookup and
// a pending mask for hazard detection.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   ld_valid/addr/data/ready     load result handshake (fixed priority)
//   alu_valid/addr/data/ready    ALU result handshake
//   sig_regWrite/wrReg_addr/wr_data  regfile write port, driven from queue state
//   rdReg_addr1/2                bypass lookup addresses
//   fwd_hit1/2, fwd_data1/2      youngest queued write for each lookup
//   pending                      per-register "write in flight" mask
//   full, empty                  queue status
module reg_writeback_buffer
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_valid,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   output logic                ld_ready,
   input  logic                alu_valid,
   input  logic [ADDR_W-1:0]   alu_addr,
   input  logic [DATA_W-1:0]   alu_data,
   output logic                alu_ready,
   output logic                sig_regWrite,
   output logic [ADDR_W-1:0]   wrReg_addr,
   output logic [DATA_W-1:0]   wr_data,
   input  logic [ADDR_W-1:0]   rdReg_addr1,
   input  logic [ADDR_W-1:0]   rdReg_addr2,
   output logic                fwd_hit1,
   output logic [DATA_W-1:0]   fwd_data1,
   output logic                fwd_hit2,
   output logic [DATA_W-1:0]   fwd_data2,
   output logic [NUM_REGS-1:0] pending,
   output logic                full,
   output logic                empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   wb_entry_t             push_entry;
   wb_entry_t             head;
   wb_entry_t [DEPTH-1:0] entries;
   logic      [DEPTH-1:0] valid;
   logic      [PTR_W-1:0] rd_ptr;
   logic                  push;
   logic                  q_full;
   logic                  q_empty;
   logic      [PTR_W-1:0] scan_idx;

   // Readies look only at registered occupancy and ld_valid.
   assign ld_ready  = !q_full;
   assign alu_ready = !q_full && !ld_valid;
   assign push      = (ld_valid && ld_ready) || (alu_valid && alu_ready);

   // Load wins the single enqueue slot.
   always_comb begin
      push_entry = '0;
      if (ld_valid) begin
         push_entry.addr = ld_addr;
         push_entry.data = ld_data;
      end else begin
         push_entry.addr = alu_addr;
         push_entry.data = alu_data;
      end
   end

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (!q_empty),
      .head       (head),
      .entries    (entries),
      .valid      (valid),
      .rd_ptr     (rd_ptr),
      .full       (q_full),
      .empty      (q_empty)
   );

   // Head retires every non-empty cycle; address and data forced to 0 otherwise.
   assign sig_regWrite = !q_empty;
   assign wrReg_addr   = q_empty ? '0 : head.addr;
   assign wr_data      = q_empty ? '0 : head.data;
   assign full         = q_full;
   assign empty        = q_empty;

   // Bypass: walk oldest to youngest so the last match left standing is the youngest.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         scan_idx = rd_ptr + PTR_W'(k);
         if (valid[scan_idx] && (entries[scan_idx].addr == rdReg_addr1)) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = entries[scan_idx].data;
         end
         if (valid[scan_idx] && (entries[scan_idx].addr == rdReg_addr2)) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = entries[scan_idx].data;
         end
      end
   end

   // Pending mask: any occupied slot targeting register r.
   always_comb begin
      pending = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == ADDR_W'(r))) begin
               pending[r] = 1'b1;
            end
         end
      end
   end

endmodule : reg_writeback_buffer

// File: tb/tb_reg_writeback_buffer.sv
// Directed and random bench for reg_writeback_buffer.
module tb_reg_writeback_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic        ld_valid;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic        alu_valid;
   logic [2:0]  alu_addr;
   logic [15:0] alu_data;
   logic        alu_ready;
   logic        sig_regWrite;
   logic [2:0]  wrReg_addr;
   logic [15:0] wr_data;
   logic [2:0]  rdReg_addr1;
   logic [2:0]  rdReg_addr2;
   logic        fwd_hit1;
   logic [15:0] fwd_data1;
   logic        fwd_hit2;
   logic [15:0] fwd_data2;
   logic [7:0]  pending;
   logic        full;
   logic        empty;

   int n_vec;
   int n_err;

   reg_writeback_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ld_valid     (ld_valid),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_ready     (ld_ready),
      .alu_valid    (alu_valid),
      .alu_addr     (alu_addr),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .sig_regWrite (sig_regWrite),
      .wrReg_addr   (wrReg_addr),
      .wr_data      (wr_data),
      .rdReg_addr1  (rdReg_addr1),
      .rdReg_addr2  (rdReg_addr2),
      .fwd_hit1     (fwd_hit1),
      .fwd_data1    (fwd_data1),
      .fwd_hit2     (fwd_hit2),
      .fwd_data2    (fwd_data2),
      .pending      (pending),
      .full         (full),
      .empty        (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      ld_valid  = 1'b0;
      ld_addr   = '0;
      ld_data   = '0;
      alu_valid = 1'b0;
      alu_addr  = '0;
      alu_data  = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      rdReg_addr1 = 3'd0;
      rdReg_addr2 = 3'd0;
      #12;
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== 20'h0) begin
         n_err++;
         $display("FAIL reset_write: got %b/%0d/%h want 0/0/0000", sig_regWrite, wrReg_addr, wr_data);
      end
      n_vec++;
      if ({pending, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== 42'h0) begin
         n_err++;
         $display("FAIL reset_bypass: got pend=%h hit=%b%b want 00/00", pending, fwd_hit1, fwd_hit2);
      end
      n_vec++;
      if ({empty, full, ld_ready, alu_ready} !== 4'b1011) begin
         n_err++;
         $display("FAIL reset_status: got e/f/lr/ar=%b want 1011", {empty, full, ld_ready, alu_ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_load();
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 3'd3; ld_data = 16'h0045;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'd3, 16'h0045}) begin
         n_err++;
         $display("FAIL single_write: got %b/%0d/%h want 1/3/0045", sig_regWrite, wrReg_addr, wr_data);
      end
      @(negedge clk);
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data, empty} !== {1'b0, 3'd0, 16'h0, 1'b1}) begin
         n_err++;
         $display("FAIL single_after: got %b/%0d/%h empty=%b want 0/0/0000 empty=1", sig_regWrite, wrReg_addr, wr_data, empty);
      end
   endtask

   task automatic test_priority();
      @(negedge clk);
      ld_valid  = 1'b1; ld_addr  = 3'd1; ld_data  = 16'h000E;
      alu_valid = 1'b1; alu_addr = 3'd2; alu_data = 16'h0004;
      #1;
      n_vec++;
      if ({ld_ready, alu_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL prio_ready: got ld/alu=%b%b want 10", ld_ready, alu_ready);
      end
      @(posedge clk);
      @(negedge clk);
      ld_valid = 1'b0;
      #1;
      n_vec++;
      if (alu_ready !== 1'b1) begin
         n_err++;
         $display("FAIL prio_alu_ready: got %b want 1", alu_ready);
      end
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'd1, 16'h000E}) begin
         n_err++;
         $display("FAIL prio_first: got %b/%0d/%h want 1/1/000e", sig_regWrite, wrReg_addr, wr_data);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'd2, 16'h0004}) begin
         n_err++;
         $display("FAIL prio_second: got %b/%0d/%h want 1/2/0004", sig_regWrite, wrReg_addr, wr_data);
      end
      @(negedge clk);
      n_vec++;
      if (sig_regWrite !== 1'b0) begin
         n_err++;
         $display("FAIL prio_idle: got %b want 0", sig_regWrite);
      end
   endtask

   // Single-source stream: drain keeps pace so the queue never fills; pointers wrap past DEPTH.
   task automatic test_stream_wrap();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         alu_valid = 1'b1; alu_addr = 3'(i); alu_data = 16'h0100 + 16'(i);
         #1;
         n_vec++;
         if ({full, alu_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL stream_ready[%0d]: got full/ready=%b%b want 01", i, full, alu_ready);
         end
         if (i > 0) begin
            n_vec++;
            if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'(i - 1), 16'h0100 + 16'(i - 1)}) begin
               n_err++;
               $display("FAIL stream_write[%0d]: got %b/%0d/%h want 1/%0d/%h", i, sig_regWrite, wrReg_addr, wr_data, i - 1, 16'h0100 + 16'(i - 1));
            end
         end
         @(posedge clk);
      end
      @(negedge clk);
      idle_inputs();
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'd5, 16'h0105}) begin
         n_err++;
         $display("FAIL stream_last: got %b/%0d/%h want 1/5/0105", sig_regWrite, wrReg_addr, wr_data);
      end
      @(negedge clk);
      n_vec++;
      if ({sig_regWrite, empty} !== 2'b01) begin
         n_err++;
         $display("FAIL stream_done: got wr/empty=%b%b want 01", sig_regWrite, empty);
      end
   endtask

   task automatic test_bypass();
      rdReg_addr1 = 3'd6;
      rdReg_addr2 = 3'd5;
      @(negedge clk);
      ld_valid = 1'b1; ld_addr = 3'd6; ld_data = 16'h0040;
      @(posedge clk);
      @(negedge clk);
      ld_data = 16'h0041;
      #1;
      n_vec++;
      if ({fwd_hit1, fwd_data1, pending} !== {1'b1, 16'h0040, 8'h40}) begin
         n_err++;
         $display("FAIL bypass_first: got hit=%b data=%h pend=%h want 1/0040/40", fwd_hit1, fwd_data1, pending);
      end
      n_vec++;
      if ({fwd_hit2, fwd_data2} !== {1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL bypass_miss: got hit2=%b data2=%h want 0/0000", fwd_hit2, fwd_data2);
      end
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      n_vec++;
      if ({fwd_hit1, fwd_data1, pending, wr_data} !== {1'b1, 16'h0041, 8'h40, 16'h0041}) begin
         n_err++;
         $display("FAIL bypass_second: got hit=%b data=%h pend=%h wr=%h want 1/0041/40/0041", fwd_hit1, fwd_data1, pending, wr_data);
      end
      @(negedge clk);
      n_vec++;
      if ({fwd_hit1, fwd_data1, pending} !== {1'b0, 16'h0, 8'h00}) begin
         n_err++;
         $display("FAIL bypass_retired: got hit=%b data=%h pend=%h want 0/0000/00", fwd_hit1, fwd_data1, pending);
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [2:0]  addrs [3];
      logic [15:0] datas [3];
      addrs[0] = 3'd4; addrs[1] = 3'd5; addrs[2] = 3'd7;
      datas[0] = 16'h0111; datas[1] = 16'h0222; datas[2] = 16'h0333;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ld_valid = 1'b1; ld_addr = addrs[i]; ld_data = datas[i];
         @(posedge clk);
      end
      #1;
      idle_inputs();
      n_vec++;
      if ({sig_regWrite, wrReg_addr, wr_data} !== {1'b1, 3'd7, 16'h0333}) begin
         n_err++;
         $display("FAIL rstmid_before: got %b/%0d/%h want 1/7/0333", sig_regWrite, wrReg_addr, wr_data);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({sig_regWrite, empty, pending, wr_data} !== {1'b0, 1'b1, 8'h00, 16'h0}) begin
         n_err++;
         $display("FAIL rstmid_async: got wr=%b empty=%b pend=%h data=%h want 0/1/00/0000", sig_regWrite, empty, pending, wr_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++;
         if ({sig_regWrite, empty} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_after[%0d]: got wr/empty=%b%b want 01", i, sig_regWrite, empty);
         end
      end
   endtask

   // Random traffic against a reference queue, checked every cycle.
   task automatic test_random();
      logic [2:0]  qa [$];
      logic [15:0] qd [$];
      logic        e_hit1, e_hit2, e_full, e_empty, accept;
      logic [15:0] e_d1, e_d2;
      logic [7:0]  e_pend;
      logic [2:0]  e_addr;
      logic [15:0] e_data;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         ld_valid    = ($urandom_range(0, 3) == 0);
         ld_addr     = 3'($urandom);
         ld_data     = 16'($urandom);
         alu_valid   = ($urandom_range(0, 1) == 1);
         alu_addr    = 3'($urandom);
         alu_data    = 16'($urandom);
         rdReg_addr1 = 3'($urandom);
         rdReg_addr2 = 3'($urandom);
         #1;
         e_empty = (qa.size() == 0);
         e_full  = (qa.size() == DEPTH);
         e_addr  = e_empty ? 3'd0 : qa[0];
         e_data  = e_empty ? 16'h0 : qd[0];
         e_hit1 = 1'b0; e_d1 = 16'h0; e_hit2 = 1'b0; e_d2 = 16'h0; e_pend = 8'h0;
         for (int j = 0; j < qa.size(); j++) begin
            e_pend[qa[j]] = 1'b1;
            if (qa[j] == rdReg_addr1) begin e_hit1 = 1'b1; e_d1 = qd[j]; end
            if (qa[j] == rdReg_addr2) begin e_hit2 = 1'b1; e_d2 = qd[j]; end
         end
         n_vec++;
         if ({sig_regWrite, wrReg_addr, wr_data} !== {!e_empty, e_addr, e_data}) begin
            n_err++;
            $display("FAIL rand_write@%0d: got %b/%0d/%h want %b/%0d/%h", cyc, sig_regWrite, wrReg_addr, wr_data, !e_empty, e_addr, e_data);
         end
         n_vec++;
         if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, pending} !== {e_hit1, e_d1, e_hit2, e_d2, e_pend}) begin
            n_err++;
            $display("FAIL rand_bypass@%0d: got %b/%h %b/%h pend=%h want %b/%h %b/%h pend=%h", cyc, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, pending, e_hit1, e_d1, e_hit2, e_d2, e_pend);
         end
         n_vec++;
         if ({full, empty, ld_ready, alu_ready} !== {e_full, e_empty, !e_full, !e_full && !ld_valid}) begin
            n_err++;
            $display("FAIL rand_status@%0d: got f/e/lr/ar=%b want %b", cyc, {full, empty, ld_ready, alu_ready}, {e_full, e_empty, !e_full, !e_full && !ld_valid});
         end
         accept = !e_full && (ld_valid || alu_valid);
         @(posedge clk);
         if (!e_empty) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
         end
         if (accept) begin
            qa.push_back(ld_valid ? ld_addr : alu_addr);
            qd.push_back(ld_valid ? ld_data : alu_data);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_single_load();
      test_priority();
      test_stream_wrap();
      test_bypass();
      test_reset_mid_drain();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_reg_writeback_buffer
